shiftrows_pipe: RTL and testbench
=================================

Name: shiftrows_pipe

Overview:
- Registered, elastic ShiftRows / InvShiftRows stage for the AES/Rijndael round datapath.
- Generalised to block widths NB = 4, 6 or 8 columns, with the direction selectable per transaction.
- Sits between SubBytes and MixColumns in an iterative or unrolled round. Uses a valid/ready handshake with a 2-entry skid buffer, so back-pressure never creates a combinational path from downstream ready to upstream ready.

Parameters:
- WORD, 32, column width in bits. Must be 32; any other value is an elaboration error.
- NB, 4, number of state columns. Legal values 4, 6, 8; any other value is an elaboration error.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  upstream block valid.
- o_ready  out  1  stage can accept; registered.
- i_inv  in  1  0 = ShiftRows (encrypt), 1 = InvShiftRows (decrypt); sampled with i_block.
- i_block  in  WORD*NB  input state.
- o_valid  out  1  output block valid.
- i_ready  in  1  downstream accepts.
- o_inv  out  1  i_inv carried alongside the block.
- o_block  out  WORD*NB  permuted state.

Behaviour:
- Byte map: column c occupies bits [WORD*NB-1-32c -: 32]. Byte s(r,c) occupies bits [WORD*NB-1-8(4c+r) -: 8]. Column 0 and row 0 are at the MSBs.
- Row offsets sh(r):
  - NB=4 or 6: 0,1,2,3.
  - NB=8: 0,1,3,4.
- Forward transform: out s(r,c) = in s(r,(c+sh(r)) mod NB).
- Inverse transform: out s(r,c) = in s(r,(c-sh(r)) mod NB).
- The permutation is applied combinationally to i_block before capture. Registers hold already-permuted data.
- Storage: main register (drives o_block/o_inv) and skid register, each with a full flag.
- States (o_valid = main_full, o_ready = !skid_full):
  - EMPTY: main and skid empty.
  - ONE: main full, skid empty.
  - TWO: main and skid full.
- Transfers: accept = i_valid && o_ready; emit = o_valid && i_ready.
- EMPTY:
  - accept: capture into main, go to ONE.
  - no accept: stay in EMPTY.
- ONE:
  - accept && emit: main <= new block, stay in ONE.
  - accept && !emit: new block goes to skid, go to TWO.
  - !accept && emit: go to EMPTY.
  - neither: hold.
- TWO (o_ready=0, no accept possible):
  - emit: main <= skid, skid cleared, go to ONE.
  - no emit: hold.
- Latency: a block accepted at edge N is presented with o_valid=1 from edge N onward. Registered latency is 1 cycle.
- Throughput: 1 block/cycle while i_ready=1.
- Ordering: strictly FIFO. No block is dropped or duplicated.
- Output stability: while o_valid && !i_ready, o_block and o_inv hold stable.
- i_inv is per-block. Mixed directions in consecutive beats are legal, and each block uses its own i_inv.
- When main is empty, o_block/o_inv keep their last value; they are don't-care.
- Reset (async assert, sync deassert handled upstream):
  - o_valid=0, o_ready=1, o_block=0, o_inv=0, skid cleared.
  - Reset mid-transfer discards both entries immediately.
- Simultaneous i_valid with o_ready=0: not accepted. Upstream must hold i_block/i_inv stable until accepted.

Test Plan:
- NB=4, i_inv=0, i_block=0xd42711aee0bf98f1b8b45de51e415230, i_ready=1 -> one cycle later o_valid=1, o_block=0xd4bf5d30e0b452aeb84111f11e2798e5, o_inv=0.
- NB=4, i_inv=1, i_block=0xd4bf5d30e0b452aeb84111f11e2798e5 -> o_block=0xd42711aee0bf98f1b8b45de51e415230, o_inv=1.
- NB=8, i_inv=0, bytes 0x00..0x1f in index order (byte k = s(k%4, k/4)) -> column 0 of o_block = 0x00050e13. Then feed that result with i_inv=1 -> original 0x00..0x1f returned.
- Back-pressure: stream 4 blocks with i_ready=0 -> o_ready drops after 2 accepts. Raise i_ready -> blocks emerge in order, none lost, o_block stable while stalled.
- Random i_valid/i_ready over 10k beats, NB in {4,6,8}, mixed i_inv -> output equals the reference model per block, in order.
- Assert i_rst_n=0 while in TWO -> o_valid=0 and o_ready=1 immediately. Post-reset, first accepted block is output correctly.

Source files
------------

// File: rtl/shiftrows_pipe.sv
// Elastic AES ShiftRows / InvShiftRows stage for NB = 4, 6 or 8 columns.
// Blocks are permuted on the way in and parked in a main register backed by a one-deep skid.
module shiftrows_pipe #(
   parameter int WORD = 32,
   parameter int NB   = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic                 i_inv,
   input  logic [WORD*NB-1:0]   i_block,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic                 o_inv,
   output logic [WORD*NB-1:0]   o_block
);
   localparam int W = WORD * NB;

   generate
      if (WORD != 32) begin : g_badWord
         $error("shiftrows_pipe: WORD must be 32");
      end
      if (NB != 4 && NB != 6 && NB != 8) begin : g_badNb
         $error("shiftrows_pipe: NB must be 4, 6 or 8");
      end
   endgenerate

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   state_t        r_state;
   state_t        w_nextState;
   logic [W-1:0]  r_mainBlock;
   logic [W-1:0]  r_skidBlock;
   logic [W-1:0]  w_permBlock;
   logic          r_mainInv;
   logic          r_skidInv;
   logic          w_accept;
   logic          w_emit;
   logic          w_loadMainIn;
   logic          w_loadMainSkid;
   logic          w_loadSkid;

   // Rows 2 and 3 of the 8-column variant shift one column further than their index.
   function automatic int srcCol(input int c, input int r, input logic inv);
      int sh;
      sh = (NB == 8 && r >= 2) ? r + 1 : r;
      return inv ? (c - sh + NB) % NB : (c + sh) % NB;
   endfunction

   always_comb begin
      w_permBlock = '0;
      for (int c = 0; c < NB; c++) begin
         for (int r = 0; r < 4; r++) begin
            w_permBlock[W-1-8*(4*c+r) -: 8] = i_block[W-1-8*(4*srcCol(c, r, i_inv)+r) -: 8];
         end
      end
   end

   assign o_valid  = (r_state != EMPTY);
   assign o_ready  = (r_state != TWO);
   assign w_accept = i_valid && o_ready;
   assign w_emit   = o_valid && i_ready;
   assign o_block  = r_mainBlock;
   assign o_inv    = r_mainInv;

   always_comb begin
      w_nextState    = r_state;
      w_loadMainIn   = 1'b0;
      w_loadMainSkid = 1'b0;
      w_loadSkid     = 1'b0;
      case (r_state)
         EMPTY: begin
            if (w_accept) begin
               w_loadMainIn = 1'b1;
               w_nextState  = ONE;
            end
         end
         ONE: begin
            if (w_accept && w_emit) begin
               w_loadMainIn = 1'b1;
            end else if (w_accept) begin
               w_loadSkid  = 1'b1;
               w_nextState = TWO;
            end else if (w_emit) begin
               w_nextState = EMPTY;
            end
         end
         TWO: begin
            if (w_emit) begin
               w_loadMainSkid = 1'b1;
               w_nextState    = ONE;
            end
         end
         default: w_nextState = EMPTY;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Reset empties both slots at once, even mid-transfer.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mainBlock <= '0;
         r_mainInv   <= 1'b0;
         r_skidBlock <= '0;
         r_skidInv   <= 1'b0;
      end else begin
         if (w_loadMainIn) begin
            r_mainBlock <= w_permBlock;
            r_mainInv   <= i_inv;
         end else if (w_loadMainSkid) begin
            r_mainBlock <= r_skidBlock;
            r_mainInv   <= r_skidInv;
         end
         if (w_loadSkid) begin
            r_skidBlock <= w_permBlock;
            r_skidInv   <= i_inv;
         end
      end
   end

endmodule

// File: tb/tb_shiftrows_pipe.sv
// Bench for shiftrows_pipe: NB = 4, 6 and 8 instances side by side, each checked
// every cycle against a byte-array ShiftRows model and a FIFO scoreboard.
module tb_shiftrows_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic         iValid [3];
   logic         iReady [3];
   logic         iInv   [3];
   logic [255:0] iBlock [3];
   logic         oValid [3];
   logic         oReady [3];
   logic         oInv   [3];
   logic [255:0] oBlock [3];

   int checks = 0;
   int errors = 0;
   int pending [3] = '{0, 0, 0};

   localparam logic [255:0] NB4_PLAIN   = 256'hd42711aee0bf98f1b8b45de51e415230;
   localparam logic [255:0] NB4_SHIFTED = 256'hd4bf5d30e0b452aeb84111f11e2798e5;
   localparam logic [255:0] SEQ32 =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

   // Reference: unpack into bytes s(r,c) = byte 4c+r, rotate each row, repack right-aligned.
   function automatic logic [255:0] refShift(input logic [255:0] blk, input int nb, input logic inv);
      logic [7:0]   inB  [32];
      logic [7:0]   outB [32];
      int           shTab [4];
      logic [255:0] res;
      if (nb == 8) shTab = '{0, 1, 3, 4};
      else         shTab = '{0, 1, 2, 3};
      for (int k = 0; k < 4 * nb; k++) inB[k] = blk[32*nb-1-8*k -: 8];
      for (int c = 0; c < nb; c++) begin
         for (int r = 0; r < 4; r++) begin
            int src;
            src = inv ? (c - shTab[r] + nb) % nb : (c + shTab[r]) % nb;
            outB[4*c+r] = inB[4*src+r];
         end
      end
      res = '0;
      for (int k = 0; k < 4 * nb; k++) res = (res << 8) | 256'(outB[k]);
      return res;
   endfunction

   function automatic logic [255:0] randBlock();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Present one block on instance g and return at #1 after the edge that accepted it.
   task automatic applyStimulus(input int g, input logic inv, input logic [255:0] blk);
      bit got;
      got = 0;
      @(posedge clk); #1;
      iValid[g] = 1'b1;
      iInv[g]   = inv;
      iBlock[g] = blk;
      for (int t = 0; t < 20 && !got; t++) begin
         @(negedge clk);
         if (oReady[g]) got = 1;
         @(posedge clk); #1;
      end
      iValid[g] = 1'b0;
      if (!got) begin
         errors++;
         $display("[TB] FAIL accept timeout on instance %0d: got no accept expected accept", g);
      end
   endtask

   generate
      for (genvar g = 0; g < 3; g++) begin : g_dut
         localparam int NBG = (g == 0) ? 4 : (g == 1) ? 6 : 8;
         logic [32*NBG-1:0] wOut;
         logic              wValid;
         logic              wReady;
         logic              wInv;

         shiftrows_pipe #(.WORD(32), .NB(NBG)) u_dut (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .i_valid (iValid[g]),
            .o_ready (wReady),
            .i_inv   (iInv[g]),
            .i_block (iBlock[g][32*NBG-1:0]),
            .o_valid (wValid),
            .i_ready (iReady[g]),
            .o_inv   (wInv),
            .o_block (wOut)
         );

         assign oBlock[g] = 256'(wOut);
         assign oValid[g] = wValid;
         assign oReady[g] = wReady;
         assign oInv[g]   = wInv;

         logic [256:0] expQ [$];
         logic [256:0] expHead;
         logic [255:0] prevBlk;
         logic         prevInv;
         bit           stallPrev = 0;

         // Transfers happen at the next rising edge; evaluate them mid-cycle.
         always @(negedge clk) begin
            if (!rst_n) begin
               expQ.delete();
               stallPrev  = 0;
               pending[g] = 0;
            end else begin
               if (stallPrev) begin
                  checks++;
                  if (!oValid[g] || oBlock[g] !== prevBlk || oInv[g] !== prevInv) begin
                     errors++;
                     $display("[TB] FAIL stall hold nb=%0d: got v=%0b inv=%0b %h expected v=1 inv=%0b %h",
                              NBG, oValid[g], oInv[g], oBlock[g], prevInv, prevBlk);
                  end
               end
               if (oValid[g] && iReady[g]) begin
                  checks++;
                  if (expQ.size() == 0) begin
                     errors++;
                     $display("[TB] FAIL unexpected output nb=%0d: got %h expected no block", NBG, oBlock[g]);
                  end else begin
                     expHead = expQ.pop_front();
                     if (oBlock[g] !== expHead[255:0] || oInv[g] !== expHead[256]) begin
                        errors++;
                        $display("[TB] FAIL block order nb=%0d: got inv=%0b %h expected inv=%0b %h",
                                 NBG, oInv[g], oBlock[g], expHead[256], expHead[255:0]);
                     end
                  end
               end
               if (iValid[g] && oReady[g])
                  expQ.push_back({iInv[g], refShift(iBlock[g], NBG, iInv[g])});
               stallPrev  = oValid[g] && !iReady[g];
               prevBlk    = oBlock[g];
               prevInv    = oInv[g];
               pending[g] = expQ.size();
            end
         end
      end
   endgenerate

   initial begin
      logic [255:0] bp [4];
      logic [255:0] fb;
      bit           acc [3];
      bit           a;
      int           n;

      rst_n = 1'b0;
      for (int g = 0; g < 3; g++) begin
         iValid[g] = 1'b0;
         iReady[g] = 1'b1;
         iInv[g]   = 1'b0;
         iBlock[g] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int g = 0; g < 3; g++) begin
         checkOutput($sformatf("reset o_valid[%0d]", g), 256'(oValid[g]), 256'd0);
         checkOutput($sformatf("reset o_ready[%0d]", g), 256'(oReady[g]), 256'd1);
         checkOutput($sformatf("reset o_block[%0d]", g), oBlock[g], 256'd0);
         checkOutput($sformatf("reset o_inv[%0d]", g), 256'(oInv[g]), 256'd0);
      end
      rst_n = 1'b1;

      applyStimulus(0, 1'b0, NB4_PLAIN);
      checkOutput("nb4 fwd o_valid", 256'(oValid[0]), 256'd1);
      checkOutput("nb4 fwd o_block", oBlock[0], NB4_SHIFTED);
      checkOutput("nb4 fwd o_inv", 256'(oInv[0]), 256'd0);

      applyStimulus(0, 1'b1, NB4_SHIFTED);
      checkOutput("nb4 inv o_block", oBlock[0], NB4_PLAIN);
      checkOutput("nb4 inv o_inv", 256'(oInv[0]), 256'd1);

      applyStimulus(2, 1'b0, SEQ32);
      checkOutput("nb8 fwd column0", 256'(oBlock[2][255:224]), 256'h00050e13);
      fb = oBlock[2];
      applyStimulus(2, 1'b1, fb);
      checkOutput("nb8 round trip", oBlock[2], SEQ32);
      checkOutput("nb8 round trip o_inv", 256'(oInv[2]), 256'd1);

      // Back-pressure: four blocks offered with downstream stalled.
      for (int k = 0; k < 4; k++) bp[k] = randBlock();
      iReady[0] = 1'b0;
      n = 0;
      @(posedge clk); #1;
      iValid[0] = 1'b1;
      iInv[0]   = 1'b0;
      iBlock[0] = bp[0];
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         a = iValid[0] && oReady[0];
         @(posedge clk); #1;
         if (a) begin
            n++;
            iInv[0]   = 1'($urandom_range(0, 1));
            iBlock[0] = bp[n];
         end
      end
      checkOutput("backpressure accepts", 256'(n), 256'd2);
      checkOutput("backpressure o_ready", 256'(oReady[0]), 256'd0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("backpressure head held", oBlock[0], refShift(bp[0], 4, 1'b0));
      iReady[0] = 1'b1;
      for (int t = 0; t < 20 && n < 4; t++) begin
         @(negedge clk);
         a = iValid[0] && oReady[0];
         @(posedge clk); #1;
         if (a) begin
            n++;
            if (n < 4) begin
               iInv[0]   = 1'($urandom_range(0, 1));
               iBlock[0] = bp[n];
            end
         end
      end
      iValid[0] = 1'b0;
      checkOutput("backpressure all accepted", 256'(n), 256'd4);
      repeat (5) @(posedge clk);
      #1;
      checkOutput("backpressure drained", 256'(pending[0]), 256'd0);

      // Reset while both slots are full.
      iReady[0] = 1'b0;
      n = 0;
      @(posedge clk); #1;
      iValid[0] = 1'b1;
      iInv[0]   = 1'b1;
      iBlock[0] = randBlock();
      for (int t = 0; t < 10 && n < 2; t++) begin
         @(negedge clk);
         a = iValid[0] && oReady[0];
         @(posedge clk); #1;
         if (a) begin
            n++;
            iBlock[0] = randBlock();
         end
      end
      iValid[0] = 1'b0;
      checkOutput("full o_ready", 256'(oReady[0]), 256'd0);
      checkOutput("full o_valid", 256'(oValid[0]), 256'd1);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async reset o_valid", 256'(oValid[0]), 256'd0);
      checkOutput("async reset o_ready", 256'(oReady[0]), 256'd1);
      repeat (2) @(posedge clk);
      #1;
      rst_n     = 1'b1;
      iReady[0] = 1'b1;
      applyStimulus(0, 1'b0, NB4_PLAIN);
      checkOutput("post reset o_block", oBlock[0], NB4_SHIFTED);
      checkOutput("post reset o_valid", 256'(oValid[0]), 256'd1);

      // Randomised traffic on all three widths at once.
      for (int cyc = 0; cyc < 10000; cyc++) begin
         @(negedge clk);
         for (int g = 0; g < 3; g++) acc[g] = iValid[g] && oReady[g];
         @(posedge clk); #1;
         for (int g = 0; g < 3; g++) begin
            if (!iValid[g] || acc[g]) begin
               iValid[g] = ($urandom_range(0, 3) != 0);
               iInv[g]   = 1'($urandom_range(0, 1));
               iBlock[g] = randBlock();
            end
            iReady[g] = ($urandom_range(0, 3) != 0);
         end
      end

      for (int g = 0; g < 3; g++) begin
         iValid[g] = 1'b0;
         iReady[g] = 1'b1;
      end
      repeat (10) @(posedge clk);
      #1;
      for (int g = 0; g < 3; g++) begin
         checkOutput($sformatf("drain pending[%0d]", g), 256'(pending[g]), 256'd0);
         checkOutput($sformatf("drain o_valid[%0d]", g), 256'(oValid[g]), 256'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
